// File: rtl/scan_pkg.sv
// Shared definitions for the scan-chain loader: chain geometry and FSM states.
package scan_pkg;

  localparam int SCAN_BYTE_W    = 8;
  // 31 memory bytes, 1 button bit, 7 LED bits.
  localparam int SCAN_CHAIN_LEN = 31 * 8 + 1 + 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_EMIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/scan_byte_shifter.sv
// One byte of serial traffic: transmit register (MSB first), receive register
// fed from the chain tail, and a per-byte shift counter.
module scan_byte_shifter
  import scan_pkg::*;
#(
  parameter int BYTE_W = SCAN_BYTE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [BYTE_W-1:0] load_data,
  input  logic              scan_out,
  output logic              tx_msb,
  output logic [BYTE_W-1:0] rx_data,
  output logic              last
);

  localparam int CW = $clog2(BYTE_W + 1);

  logic [BYTE_W-1:0] tx_sr;
  logic [BYTE_W-1:0] rx_sr;
  logic [CW-1:0]     shift_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_sr     <= '0;
      rx_sr     <= '0;
      shift_cnt <= '0;
    end else if (load) begin
      tx_sr     <= load_data;
      shift_cnt <= '0;
    end else if (shift) begin
      tx_sr     <= {tx_sr[BYTE_W-2:0], 1'b0};
      rx_sr     <= {rx_sr[BYTE_W-2:0], scan_out};
      shift_cnt <= shift_cnt + CW'(1);
    end
  end

  assign tx_msb  = tx_sr[BYTE_W-1];
  assign rx_data = rx_sr;
  // High during the final shift cycle of the current byte.
  assign last    = (shift_cnt == CW'(BYTE_W - 1));

endmodule

// File: rtl/scan_chain_loader.sv
// Byte-wide front-end for the memory-bank scan chain: each pass loads new
// contents and returns the previous contents, tail bits first.
module scan_chain_loader
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN = SCAN_CHAIN_LEN,
  parameter int BYTE_W    = SCAN_BYTE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              scan_enable,
  output logic              scan_in,
  input  logic              scan_out,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);

  // Handshakes: a byte moves on in_data when in_valid && in_ready at a rising
  // edge, and on out_data when out_valid && out_ready at a rising edge; both
  // ready/valid flags are registered and never high together.
  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic              load;
  logic              shift;
  logic              tx_msb;
  logic              last;
  logic [BYTE_W-1:0] rx_data;

  assign load  = (state == ST_FETCH) && in_valid && in_ready && !abort;
  assign shift = (state == ST_SHIFT) && !abort;

  scan_byte_shifter #(.BYTE_W(BYTE_W)) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .shift     (shift),
    .load_data (in_data),
    .scan_out  (scan_out),
    .tx_msb    (tx_msb),
    .rx_data   (rx_data),
    .last      (last)
  );

  // Gated so both serial-side and byte-side outputs read 0 outside their phase.
  assign scan_in  = scan_enable & tx_msb;
  assign out_data = out_valid ? rx_data : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      scan_enable <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else if (abort && state != ST_IDLE) begin
      state       <= ST_IDLE;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      scan_enable <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_FETCH;
            bit_cnt  <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (in_valid) begin
            state       <= ST_SHIFT;
            in_ready    <= 1'b0;
            scan_enable <= 1'b1;
          end
        end
        ST_SHIFT: begin
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (last) begin
            state       <= ST_EMIT;
            scan_enable <= 1'b0;
            out_valid   <= 1'b1;
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (bit_cnt == CNT_W'(CHAIN_LEN)) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state    <= ST_FETCH;
              in_ready <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_chain_loader.sv
// Bench for scan_chain_loader: a 256-bit chain driven by the DUT plus a
// bit-queue image of the chain used to predict every read-back byte.
module tb_scan_chain_loader;

  localparam int CL = 256;
  localparam int BW = 8;
  localparam int NB = CL / BW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [BW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          scan_enable;
  logic          scan_in;
  logic          scan_out;
  logic          busy;
  logic          done;

  scan_chain_loader dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .scan_enable (scan_enable),
    .scan_in     (scan_in),
    .scan_out    (scan_out),
    .busy        (busy),
    .done        (done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- physical chain ----------------
  logic [CL-1:0] chain = '0;
  int            se_cnt = 0;
  int            cyc = 0;

  assign scan_out = chain[CL-1];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (scan_enable) begin
      chain  <= {chain[CL-2:0], scan_in};
      se_cnt <= se_cnt + 1;
    end
  end

  // ---------------- scoreboard ----------------
  int            checks = 0;
  int            errors = 0;
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] got_q[$];
  bit            img_q[$];
  logic [BW-1:0] tx[NB];
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            start_cyc = 0;
  logic          done_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not seen within bound", name);
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    check("handshake_exclusive", 32'(in_ready & out_valid), 32'd0);
    if (!busy)
      check("idle_outputs", 32'({in_ready, out_valid, out_data, scan_enable, scan_in, done}), 32'd0);
    if (scan_enable)
      check("shift_quiet", 32'({in_ready, out_valid}), 32'd0);
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        fail("out_unexpected");
      end else begin
        check("out_data", 32'(out_data), 32'(exp_q[0]));
        if (out_ready) begin
          got_q.push_back(out_data);
          void'(exp_q.pop_front());
        end
      end
    end
    if (done) begin
      check("done_single_cycle", 32'(done_prev), 32'd0);
      done_cnt++;
      done_cyc = cyc;
    end
    done_prev = done;
  end

  // ---------------- model helpers ----------------
  // Read-back of a pass is the image read from the tail, 8 bits per byte.
  task automatic push_expected();
    logic [BW-1:0] b;
    exp_q.delete();
    got_q.delete();
    for (int k = 0; k < NB; k++) begin
      b = '0;
      for (int m = 0; m < BW; m++) b = {b[BW-2:0], img_q[k*BW+m]};
      exp_q.push_back(b);
    end
  endtask

  // Each chain shift drops the tail bit and appends the next MSB-first tx bit.
  task automatic apply_bits(input int n);
    logic [BW-1:0] b;
    for (int i = 0; i < n; i++) begin
      b = tx[i / BW];
      void'(img_q.pop_front());
      img_q.push_back(b[BW-1 - (i % BW)]);
    end
  endtask

  task automatic check_chain();
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < CL; i++)
      if (chain[CL-1-i] !== img_q[i]) ok = 1'b0;
    check("chain_image", 32'(ok), 32'd1);
  endtask

  // ---------------- drivers ----------------
  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [BW-1:0] b);
    bit ok;
    ok = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!ok) fail("fetch_timeout");
  endtask

  task automatic backpressure();
    bit            seen;
    logic [BW-1:0] held;
    out_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    if (!seen) fail("emit_timeout");
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_stable", 32'(out_data), 32'(held));
      check("bp_scan_enable", 32'(scan_enable), 32'd0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
  endtask

  // mode 0: plain, 1: start held through SHIFT/FETCH, 2: backpressure on byte 5
  task automatic run_pass(input int mode);
    int  se0;
    int  d0;
    bit  got_done;
    push_expected();
    se0 = se_cnt;
    d0  = done_cnt;
    pulse_start();
    for (int j = 0; j < NB; j++) begin
      if (mode == 1 && j == 10) start = 1'b1;
      send_byte(tx[j]);
      if (mode == 1 && j == 10) start = 1'b0;
      if (mode == 2 && j == 5) backpressure();
    end
    got_done = 1'b0;
    for (int i = 0; i < 50 && !got_done; i++) begin
      @(negedge clk);
      if (done_cnt != d0) got_done = 1'b1;
    end
    if (!got_done) fail("done_timeout");
    repeat (3) @(negedge clk);
    check("done_count", 32'(done_cnt - d0), 32'd1);
    check("scan_enable_cycles", 32'(se_cnt - se0), 32'd256);
    check("readback_count", 32'(got_q.size()), 32'(NB));
    check("busy_after_pass", 32'(busy), 32'd0);
    if (mode != 2) check("pass_cycles", 32'(done_cyc - start_cyc + 1), 32'd322);
    apply_bits(CL);
    check_chain();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int se0;
    int d0;
    bit hit;
    for (int i = 0; i < CL; i++) img_q.push_back(1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({in_ready, out_valid, out_data, scan_enable, scan_in, busy, done}), 32'd0);
    rst = 1'b1;

    // abort while idle does nothing
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_idle_busy", 32'(busy), 32'd0);

    // pass 1: zero chain, bytes 0x01..0x20
    for (int i = 0; i < NB; i++) tx[i] = 8'(i + 1);
    run_pass(0);
    check("p1_chain_head", 32'(chain[CL-1 -: 8]), 32'h01);
    check("p1_chain_last", 32'(chain[7:0]), 32'h20);
    check("p1_first_out", 32'(got_q[0]), 32'h00);
    check("p1_last_out", 32'(got_q[NB-1]), 32'h00);

    // pass 2: all ones, start held high across SHIFT and FETCH
    for (int i = 0; i < NB; i++) tx[i] = 8'hFF;
    run_pass(1);
    check("p2_first_out", 32'(got_q[0]), 32'h01);
    check("p2_second_out", 32'(got_q[1]), 32'h02);
    check("p2_last_out", 32'(got_q[NB-1]), 32'h20);

    // pass 3: backpressure in EMIT of byte 5
    for (int i = 0; i < NB; i++) tx[i] = 8'(i * 37 + 5);
    run_pass(2);
    check("p3_first_out", 32'(got_q[0]), 32'hFF);

    // pass 4: abort lands on the edge of byte 3's third shift -> 19 shifts
    tx[0] = 8'h3C;
    tx[1] = 8'hC3;
    tx[2] = 8'h5A;
    push_expected();
    se0 = se_cnt;
    d0  = done_cnt;
    pulse_start();
    for (int j = 0; j < 3; j++) send_byte(tx[j]);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (se_cnt - se0 >= 18) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!hit) fail("abort_wait");
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_scan_enable", 32'(scan_enable), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    check("abort_shifts", 32'(se_cnt - se0), 32'd19);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_outs", 32'(got_q.size()), 32'd2);
    check("abort_chain_tail", 32'(chain[18:0]), 32'b0011110011000011010);
    exp_q.delete();
    apply_bits(19);
    check_chain();

    // pass 5: reset lands on the edge of byte 2's fifth shift -> 13 shifts
    tx[0] = 8'h11;
    tx[1] = 8'h22;
    push_expected();
    se0 = se_cnt;
    pulse_start();
    for (int j = 0; j < 2; j++) send_byte(tx[j]);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (se_cnt - se0 >= 12) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!hit) fail("reset_wait");
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset_shifts", 32'(se_cnt - se0), 32'd13);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_mid_outputs", 32'({in_ready, out_valid, out_data, scan_enable, scan_in, busy, done}), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    apply_bits(13);
    check_chain();

    // pass 6: fresh pass after reset must be a full, normal pass
    for (int i = 0; i < NB; i++) tx[i] = 8'(8'h80 + i);
    run_pass(0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
